// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-channel TDM receive path.
package tdm_pkg;

    localparam int NCH   = 4;
    localparam int WIDTH = 4;

    typedef logic [1:0]       slot_t;
    typedef logic [WIDTH-1:0] chan_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1
    } state_t;

endpackage

// File: rtl/tdm_demux4w4.sv
// TDM demultiplexer: collects four nibbles per frame into a shadow bank and
// publishes them together, or writes one channel directly in select mode.
module tdm_demux4w4
    import tdm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Yin,
    input  logic             Yvalid,
    input  logic             Sof,
    input  logic             Mode,
    input  logic [1:0]       Sel,
    output logic [WIDTH-1:0] D0,
    output logic [WIDTH-1:0] D1,
    output logic [WIDTH-1:0] D2,
    output logic [WIDTH-1:0] D3,
    output logic [NCH-1:0]   Dvalid,
    output logic             frame_done,
    output logic             frame_err
);

    state_t state;
    slot_t  slot;
    chan_t  shadow [NCH];

    // Frame FSM, slot counter, shadow bank and registered outputs in one place
    // so the outputs only ever move on a complete frame or a direct write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            slot       <= '0;
            D0         <= '0;
            D1         <= '0;
            D2         <= '0;
            D3         <= '0;
            Dvalid     <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            for (int i = 0; i < NCH; i++) shadow[i] <= '0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (Mode) begin
                // Leaving TDM mid-frame abandons the partial frame.
                if (state == RECV) begin
                    frame_err <= 1'b1;
                    state     <= IDLE;
                    slot      <= '0;
                end
                if (Yvalid) begin
                    case (Sel)
                        2'd0:    D0 <= Yin;
                        2'd1:    D1 <= Yin;
                        2'd2:    D2 <= Yin;
                        default: D3 <= Yin;
                    endcase
                    Dvalid[Sel] <= 1'b1;
                end
            end else if (Yvalid) begin
                case (state)
                    IDLE: begin
                        // Only a start-of-frame beat can open a frame.
                        if (Sof) begin
                            shadow[0] <= Yin;
                            slot      <= slot_t'(1);
                            state     <= RECV;
                        end
                    end
                    RECV: begin
                        if (Sof) begin
                            // Resync: drop what we have, this beat is slot 0.
                            frame_err <= 1'b1;
                            shadow[0] <= Yin;
                            slot      <= slot_t'(1);
                        end else begin
                            shadow[slot] <= Yin;
                            if (slot == slot_t'(NCH-1)) begin
                                // Last beat bypasses the shadow so it lands on this edge.
                                D0         <= shadow[0];
                                D1         <= shadow[1];
                                D2         <= shadow[2];
                                D3         <= Yin;
                                Dvalid     <= '1;
                                slot       <= '0;
                                state      <= IDLE;
                                frame_done <= 1'b1;
                            end else begin
                                slot <= slot + slot_t'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        slot  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux4w4.sv
// Directed self-checking bench for tdm_demux4w4.
module tb_tdm_demux4w4;

    logic       clk = 1'b0;
    logic       rst, Yvalid, Sof, Mode;
    logic [3:0] Yin;
    logic [1:0] Sel;
    logic [3:0] D0, D1, D2, D3;
    logic [3:0] Dvalid;
    logic       frame_done, frame_err;

    int tests = 0;
    int fails = 0;

    tdm_demux4w4 dut (
        .clk(clk), .rst(rst), .Yin(Yin), .Yvalid(Yvalid), .Sof(Sof),
        .Mode(Mode), .Sel(Sel), .D0(D0), .D1(D1), .D2(D2), .D3(D3),
        .Dvalid(Dvalid), .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic r, input logic yv, input logic sof,
                        input logic [3:0] y, input logic md, input logic [1:0] sl);
        rst = r; Yvalid = yv; Sof = sof; Yin = y; Mode = md; Sel = sl;
        @(posedge clk);
        #1;
        Yvalid = 1'b0; Sof = 1'b0; rst = 1'b0;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] d, input logic [3:0] dv,
                             input logic done, input logic err);
        check({tag, ".d"},    {D0, D1, D2, D3}, d);
        check({tag, ".dv"},   {12'h0, Dvalid}, {12'h0, dv});
        check({tag, ".done"}, {15'h0, frame_done}, {15'h0, done});
        check({tag, ".err"},  {15'h0, frame_err}, {15'h0, err});
    endtask

    initial begin
        rst = 1'b0; Yvalid = 1'b0; Sof = 1'b0; Yin = '0; Mode = 1'b0; Sel = '0;

        // Reset state
        step(1, 0, 0, 4'h0, 0, 0);
        check_all("reset", 16'h0000, 4'h0, 0, 0);

        // Back-to-back TDM frame
        step(0, 1, 1, 4'h0, 0, 0);
        step(0, 1, 0, 4'h6, 0, 0);
        step(0, 1, 0, 4'h9, 0, 0);
        check_all("frame1_partial", 16'h0000, 4'h0, 0, 0);
        step(0, 1, 0, 4'hA, 0, 0);
        check_all("frame1_done", 16'h069A, 4'hF, 1, 0);
        step(0, 0, 0, 4'h0, 0, 0);
        check_all("frame1_pulse_end", 16'h069A, 4'hF, 0, 0);

        // Gapped frame: outputs hold the previous frame until the last beat
        step(0, 1, 1, 4'h5, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 4'hF, 0, 0);
        step(0, 1, 0, 4'h6, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 4'hF, 0, 0);
        step(0, 1, 0, 4'h7, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 4'hF, 0, 0);
        check_all("gap_hold", 16'h069A, 4'hF, 0, 0);
        step(0, 1, 0, 4'h8, 0, 0);
        check_all("gap_done", 16'h5678, 4'hF, 1, 0);

        // Beat without Sof in IDLE is ignored
        step(0, 1, 0, 4'h3, 0, 0);
        check_all("idle_ignore", 16'h5678, 4'hF, 0, 0);

        // Resync on Sof mid-frame
        step(0, 1, 1, 4'h1, 0, 0);
        step(0, 1, 0, 4'h2, 0, 0);
        step(0, 1, 1, 4'h0, 0, 0);
        check_all("resync_err", 16'h5678, 4'hF, 0, 1);
        step(0, 1, 0, 4'h6, 0, 0);
        check_all("resync_err_end", 16'h5678, 4'hF, 0, 0);
        step(0, 1, 0, 4'h9, 0, 0);
        step(0, 1, 0, 4'hA, 0, 0);
        check_all("resync_done", 16'h069A, 4'hF, 1, 0);

        // Direct mode from a clean reset
        step(1, 0, 0, 4'h0, 0, 0);
        step(0, 1, 0, 4'h9, 1, 2'd2);
        check_all("direct_sel2", 16'h0090, 4'h4, 0, 0);
        step(0, 1, 1, 4'h5, 1, 2'd0);
        check_all("direct_sel0", 16'h5090, 4'h5, 0, 0);
        step(0, 0, 0, 4'hC, 1, 2'd3);
        check_all("direct_novalid", 16'h5090, 4'h5, 0, 0);

        // Abort by mode switch, then non-Sof beats in TDM are ignored
        step(0, 1, 1, 4'h3, 0, 0);
        step(0, 1, 0, 4'h5, 0, 0);
        step(0, 0, 0, 4'h0, 1, 0);
        check_all("mode_abort", 16'h5090, 4'h5, 0, 1);
        step(0, 1, 0, 4'h7, 0, 0);
        step(0, 1, 0, 4'h1, 0, 0);
        step(0, 1, 0, 4'h2, 0, 0);
        step(0, 1, 0, 4'h3, 0, 0);
        check_all("after_abort_ignored", 16'h5090, 4'h5, 0, 0);

        // Reset mid-frame: no error, everything cleared, next frame clean
        step(0, 1, 1, 4'hF, 0, 0);
        step(0, 1, 0, 4'hE, 0, 0);
        step(1, 1, 1, 4'hD, 0, 0);
        check_all("midframe_reset", 16'h0000, 4'h0, 0, 0);
        step(0, 0, 0, 4'h0, 0, 0);
        check_all("midframe_reset_after", 16'h0000, 4'h0, 0, 0);
        step(0, 1, 1, 4'hF, 0, 0);
        step(0, 1, 0, 4'hE, 0, 0);
        step(0, 1, 0, 4'hD, 0, 0);
        step(0, 1, 0, 4'hC, 0, 0);
        check_all("post_reset_frame", 16'hFEDC, 4'hF, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tdm_demux4w4.md
Name: tdm_demux4w4

Overview:
- Receive end of the 4-channel, 4-bit time-division link fed by the mux4a1w4 path.
- Accepts one nibble per valid beat, steers it to the channel slot it belongs to, and buffers a full frame in shadow registers.
- Presents all four channels together on the registered outputs D0..D3 once a complete frame has arrived.
- Also supports a direct-select mode, the exact inverse of the 4:1 mux: `Sel` picks the destination.

Parameters:
- WIDTH, 4: bits per channel.
- NCH, 4: channels per frame. Fixed at 4 for this revision; ports D0..D3 are hard-wired.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- Yin  in  WIDTH  link data beat.
- Yvalid  in  1  Yin carries a valid beat this cycle.
- Sof  in  1  start of frame; qualified by Yvalid; marks slot 0.
- Mode  in  1  0 = TDM slot counting, 1 = direct select via Sel.
- Sel  in  2  destination channel in direct mode; ignored in TDM mode.
- D0, D1, D2, D3  out  WIDTH each  registered channel outputs.
- Dvalid  out  NCH  per-channel "written since reset" flags.
- frame_done  out  1  one-cycle pulse: D0..D3 updated from a complete frame.
- frame_err  out  1  one-cycle pulse: partial frame discarded.

Behaviour:
- Reset (rst=1 at a clk edge):
  - D0..D3 = 0, shadow registers = 0, Dvalid = 0.
  - frame_done = 0, frame_err = 0.
  - State = IDLE, slot = 0.
  - Reset wins over every other input in the same cycle. Reset mid-frame discards the partial frame with no frame_err.
- States (2-bit encoding): IDLE, RECV.
- TDM mode (Mode=0):
  - IDLE:
    - Yvalid & !Sof: beat ignored, no flag.
    - Yvalid & Sof: Yin -> shadow[0], slot <= 1, go to RECV.
  - RECV:
    - Yvalid & !Sof: Yin -> shadow[slot], slot <= slot+1.
    - When the beat writes slot NCH-1: on that same edge D0..D3 <= {shadow[0..2], Yin}, Dvalid <= all ones, slot <= 0, go to IDLE. frame_done is high for the cycle after that edge.
    - Latency: last beat at edge N -> outputs and frame_done visible after edge N.
    - Yvalid & Sof in RECV (slot≠0): frame_err pulses, the partial shadow contents are abandoned, this beat is taken as slot 0 (shadow[0] <= Yin, slot <= 1), stay in RECV.
    - Yvalid=0: hold state and slot. There is no timeout; gaps between beats are legal.
  - D0..D3 change only on frame completion, so a consumer always sees a coherent frame.
- Direct mode (Mode=1):
  - Yvalid: D[Sel] <= Yin directly (1-cycle latency); Dvalid[Sel] <= 1; Sof is ignored.
  - frame_done never pulses.
  - Shadow registers are untouched.
- Mode switch:
  - Mode=1 while in RECV: frame_err pulses, state -> IDLE, slot -> 0.
  - Any Yvalid beat in that same cycle is handled as direct mode.
  - Mode 1 -> 0: starts in IDLE; the next frame must begin with Sof.
- Pulse outputs:
  - frame_done and frame_err are registered and are 0 in every cycle without their event.
  - Both can never be 1 in the same cycle.
- Arithmetic:
  - slot is a 2-bit counter. Wrap is explicit: completion returns it to 0, never to a free-running overflow.
  - No data arithmetic; width is preserved.

Decomposition:
- Package tdm_pkg:
  - state enum (IDLE, RECV).
  - localparams NCH=4, WIDTH=4.
  - typedef slot_t (logic [1:0]) and chan_t (logic [WIDTH-1:0]).
- No sub-module required. The slot counter and shadow bank stay in one always_ff; output steering is a case on slot/Sel.

Test Plan:
- Reset then TDM frame: Sof+0000, 0110, 1001, 1010 on consecutive cycles -> after 4th edge D0..D3 = 0000/0110/1001/1010, frame_done=1 for exactly 1 cycle, Dvalid=1111.
- Gapped frame: same four beats with Yvalid=0 for 3 cycles between each -> identical outputs. D0..D3 stay at the previous frame until the 4th beat.
- Resync: Sof+0001, 0010, then Sof+0000, 0110, 1001, 1010 -> frame_err=1 one cycle after 3rd beat, final D = 0000/0110/1001/1010, one frame_done.
- Direct mode: Mode=1, Sel=10, Yin=1001, Yvalid=1 -> next cycle D2=1001, Dvalid[2]=1, other outputs unchanged, frame_done=0.
- Abort by mode: Sof+0011, 0101 in TDM, then Mode=1 with Yvalid=0 -> frame_err pulse, D0..D3 unchanged, state IDLE; a later Mode=0 beat without Sof is ignored.
- Reset mid-frame: two beats, rst=1 for 1 cycle, then full frame 1111/1110/1101/1100 -> all outputs 0 after reset, no frame_err, then D = 1111/1110/1101/1100.
